// File: rtl/dma_copy.sv
// Single-channel word-copy DMA: register-programmed SRC/DST/LEN, one read then one write per word.
// Optional build macro DMA_FIXED_SRC_EN adds a fixed-source mode (CTRL bit 5) for FIFO-style sources.
module dma_copy (
    input  logic        clk,
    input  logic        rstn,
    output logic        irq,
    input  logic        dcs,
    input  logic        drd,
    input  logic        dwe,
    input  logic [3:0]  dwst,
    input  logic [31:0] dadrs,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        m_req,
    input  logic        m_gnt,
    output logic [31:0] m_adrs,
    output logic        m_rd,
    output logic        m_we,
    output logic [3:0]  m_wst,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_CAP  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]  state;
    logic [31:0] src_reg, dst_reg, len_reg;
    logic [31:0] cur_src, cur_dst, data_buf;
    logic [15:0] count;
    logic        ie, done, busy, fixsrc;
    logic        reg_we, ctrl_we, start;
    logic        rd_phase, wr_phase;
    logic [31:0] stat_word;
    logic        unused_adrs_bits;

    assign reg_we  = dcs & dwe & (dwst != 4'h0);
    assign ctrl_we = reg_we & (dadrs[3:2] == 2'd3);
    // A start is only honoured from IDLE; CTRL writes at other times still update ie/done.
    assign start   = ctrl_we & din[0] & (state == S_IDLE);
    assign unused_adrs_bits = ^{dadrs[31:4], dadrs[1:0]};

`ifdef DMA_FIXED_SRC_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fixsrc <= 1'b0;
        end else if (ctrl_we) begin
            fixsrc <= din[5];
        end
    end
    assign stat_word = {26'b0, fixsrc, 2'b0, ie, done, busy};
`else
    assign fixsrc    = 1'b0;
    assign stat_word = {29'b0, ie, done, busy};
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            src_reg <= 32'h0;
            dst_reg <= 32'h0;
            len_reg <= 32'h0;
        end else if (reg_we) begin
            case (dadrs[3:2])
                2'd0:    src_reg <= din;
                2'd1:    dst_reg <= din;
                2'd2:    len_reg <= din;
                default: ;
            endcase
        end
    end

    // done set in DONE takes priority over a same-cycle clear request.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ie   <= 1'b0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            if (ctrl_we) begin
                ie <= din[1];
                if (din[3]) done <= 1'b0;
            end
            if (start) busy <= 1'b1;
            if (state == S_DONE) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            cur_src  <= 32'h0;
            cur_dst  <= 32'h0;
            count    <= 16'h0;
            data_buf <= 32'h0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cur_src <= src_reg;
                    cur_dst <= dst_reg;
                    count   <= len_reg[15:0];
                    state   <= (len_reg[15:0] == 16'h0) ? S_DONE : S_REQ;
                end
                S_REQ:  if (m_gnt) state <= S_RD;
                S_RD:   if (m_gnt) state <= S_CAP;
                S_CAP: begin
                    data_buf <= m_rdata;
                    state    <= S_WR;
                end
                S_WR: if (m_gnt) begin
                    cur_src <= fixsrc ? cur_src : cur_src + 32'd4;
                    cur_dst <= cur_dst + 32'd4;
                    count   <= count - 16'd1;
                    state   <= (count != 16'd1) ? S_RD : S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout <= 32'h0;
        end else if (dcs & drd) begin
            case (dadrs[3:2])
                2'd0:    dout <= src_reg;
                2'd1:    dout <= dst_reg;
                2'd2:    dout <= len_reg;
                default: dout <= stat_word;
            endcase
        end
    end

    // Bus strobes are decoded from state so an asynchronous reset drops them at once.
    assign rd_phase = (state == S_RD) & m_gnt;
    assign wr_phase = (state == S_WR) & m_gnt;

    always_comb begin
        m_req   = (state == S_REQ) | (state == S_RD) | (state == S_CAP) | (state == S_WR);
        m_rd    = rd_phase;
        m_we    = wr_phase;
        m_wst   = wr_phase ? 4'hF : 4'h0;
        m_adrs  = 32'h0;
        m_wdata = 32'h0;
        if (rd_phase) m_adrs = cur_src;
        if (wr_phase) begin
            m_adrs  = cur_dst;
            m_wdata = data_buf;
        end
    end

    assign irq = done & ie;

endmodule

// File: tb/tb_dma_copy.sv
// Bench for dma_copy: bus memory model, expected-transaction queues and register-level scenarios.
module tb_dma_copy;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        irq;
    logic        dcs = 1'b0, drd = 1'b0, dwe = 1'b0;
    logic [3:0]  dwst = 4'h0;
    logic [31:0] dadrs = 32'h0, din = 32'h0;
    logic [31:0] dout;
    logic        m_req, m_rd, m_we;
    logic        m_gnt = 1'b1;
    logic [31:0] m_adrs, m_wdata;
    logic [3:0]  m_wst;
    logic [31:0] m_rdata = 32'h0;

    dma_copy dut (
        .clk(clk), .rstn(rstn), .irq(irq),
        .dcs(dcs), .drd(drd), .dwe(dwe), .dwst(dwst), .dadrs(dadrs), .din(din), .dout(dout),
        .m_req(m_req), .m_gnt(m_gnt), .m_adrs(m_adrs), .m_rd(m_rd), .m_we(m_we),
        .m_wst(m_wst), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          req_cycles = 0;
    bit          rand_gnt = 1'b0;
    bit          rd_pending = 1'b0;
    logic [31:0] rd_addr_seen = 32'h0;
    logic [31:0] salt = 32'h0;
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_wa_q[$];
    logic [31:0] exp_wd_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ salt;
    endfunction

    // Reference: word i is read from src+4i (or src when fixed) and lands at dst+4i.
    task automatic plan(input logic [31:0] s, input logic [31:0] d, input int len, input bit fix);
        logic [31:0] a;
        salt = $urandom;
        for (int i = 0; i < len; i++) begin
            a = fix ? s : s + 32'(4 * i);
            exp_rd_q.push_back(a);
            exp_wa_q.push_back(d + 32'(4 * i));
            exp_wd_q.push_back(rd_data(a));
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (m_req) req_cycles++;
            if (!m_gnt) check("strobe_without_gnt", {30'b0, m_rd, m_we}, 32'h0);
            if (m_rd) begin
                check("rd_expected", 32'(exp_rd_q.size() != 0), 32'h1);
                if (exp_rd_q.size() != 0) check("rd_adrs", m_adrs, exp_rd_q.pop_front());
                rd_addr_seen = m_adrs;
                rd_pending = 1'b1;
            end
            if (m_we) begin
                check("wr_expected", 32'(exp_wa_q.size() != 0), 32'h1);
                if (exp_wa_q.size() != 0) begin
                    check("wr_adrs", m_adrs, exp_wa_q.pop_front());
                    check("wr_data", m_wdata, exp_wd_q.pop_front());
                end
                check("wr_wst", {28'b0, m_wst}, 32'hF);
            end else begin
                check("wst_idle", {28'b0, m_wst}, 32'h0);
            end
        end
    end

    always @(posedge clk) begin
        if (rd_pending) begin
            rd_pending = 1'b0;
            #1 m_rdata = rd_data(rd_addr_seen);
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_gnt) m_gnt = ($urandom_range(0, 3) != 0);
    end

    task automatic reg_write(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] wst = 4'hF);
        @(negedge clk);
        dcs = 1'b1; dwe = 1'b1; dwst = wst; dadrs = {28'h0, idx, 2'b00}; din = data;
        @(posedge clk); #1;
        dcs = 1'b0; dwe = 1'b0; dwst = 4'h0;
    endtask

    task automatic reg_read(input logic [1:0] idx, output logic [31:0] data);
        @(negedge clk);
        dcs = 1'b1; drd = 1'b1; dadrs = {28'h0, idx, 2'b00};
        @(posedge clk); #1;
        data = dout;
        dcs = 1'b0; drd = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] st;
        int k;
        for (k = 0; k < 400; k++) begin
            reg_read(2'd3, st);
            if (st[0] == 1'b0) break;
        end
        check({tag, "_finish_in_time"}, 32'(k < 400), 32'h1);
    endtask

    task automatic wait_we(input string tag);
        int k;
        for (k = 0; k < 100; k++) begin
            @(posedge clk); #2;
            if (m_we) break;
        end
        check({tag, "_we_seen"}, 32'(k < 100), 32'h1);
    endtask

    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                            input bit ie, input bit d5, input bit poke, input string tag);
        logic [31:0] st, ctl;
        bit mfix;
`ifdef DMA_FIXED_SRC_EN
        mfix = d5;
`else
        mfix = 1'b0;
`endif
        plan(s, d, len, mfix);
        reg_write(2'd0, s);
        reg_write(2'd1, d);
        reg_write(2'd2, 32'(len));
        ctl = {26'b0, d5, 3'b000, ie, 1'b1};
        reg_write(2'd3, ctl);
        if (poke) begin
            // Re-start while busy plus fresh SRC/DST/LEN must not disturb the running copy.
            reg_write(2'd3, ctl);
            reg_write(2'd0, $urandom);
            reg_write(2'd1, $urandom);
            reg_write(2'd2, 32'($urandom_range(1, 9)));
        end
        wait_done(tag);
        check({tag, "_rd_left"}, 32'(exp_rd_q.size()), 32'h0);
        check({tag, "_wr_left"}, 32'(exp_wa_q.size()), 32'h0);
        reg_read(2'd3, st);
        check({tag, "_stat"}, st, {26'b0, mfix, 2'b00, ie, 1'b1, 1'b0});
        check({tag, "_irq"}, {31'b0, irq}, {31'b0, ie});
        reg_write(2'd3, {26'b0, d5, 1'b0, 1'b1, 1'b0, ie, 1'b0});
        check({tag, "_irq_cleared"}, {31'b0, irq}, 32'h0);
    endtask

    initial begin
        logic [31:0] rv;
        #2 rstn = 1'b0;
        #1;
        check("rst_outputs", {26'b0, m_req, m_rd, m_we, irq, |m_wst, 1'b0}, 32'h0);
        check("rst_adrs", m_adrs, 32'h0);
        check("rst_wdata", m_wdata, 32'h0);
        check("rst_dout", dout, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rstn = 1'b1;
        reg_read(2'd3, rv); check("rst_stat", rv, 32'h0);
        reg_read(2'd0, rv); check("rst_src", rv, 32'h0);

        reg_write(2'd0, 32'h1234_5678, 4'h0);
        reg_read(2'd0, rv); check("wst_zero_ignored", rv, 32'h0);
        reg_write(2'd1, 32'hCAFE_F00D, 4'h2);
        reg_read(2'd1, rv); check("dst_readback", rv, 32'hCAFE_F00D);

        req_cycles = 0;
        run_xfer(32'h1000_0000, 32'h2000_0000, 3, 1'b0, 1'b0, 1'b0, "basic");
        check("basic_req_cycles", 32'(req_cycles), 32'd10);
        reg_read(2'd2, rv); check("len_readback", rv, 32'd3);

        reg_write(2'd2, 32'h0);
        reg_write(2'd3, 32'h3);
        check("len0_irq_early", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        check("len0_irq", {31'b0, irq}, 32'h1);
        reg_read(2'd3, rv); check("len0_stat", rv, 32'h6);
        check("len0_no_bus", 32'(exp_rd_q.size() + exp_wa_q.size()), 32'h0);
        reg_write(2'd3, 32'hA);
        check("len0_irq_cleared", {31'b0, irq}, 32'h0);
        reg_read(2'd3, rv); check("len0_stat_cleared", rv, 32'h4);

        plan(32'h3000_0000, 32'h5000_0000, 3, 1'b0);
        reg_write(2'd0, 32'h3000_0000);
        reg_write(2'd1, 32'h5000_0000);
        reg_write(2'd2, 32'd3);
        reg_write(2'd3, 32'h1);
        wait_we("stall");
        @(posedge clk); #1;
        m_gnt = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("stall_req", {31'b0, m_req}, 32'h1);
            check("stall_no_rd", {31'b0, m_rd}, 32'h0);
        end
        m_gnt = 1'b1;
        wait_done("stall");
        check("stall_rd_left", 32'(exp_rd_q.size()), 32'h0);
        check("stall_wr_left", 32'(exp_wa_q.size()), 32'h0);
        reg_write(2'd3, 32'h8);

        run_xfer(32'hFFFF_FFFC, 32'h6000_0000, 2, 1'b1, 1'b0, 1'b0, "wrap");

        plan(32'h7000_0000, 32'h8000_0000, 4, 1'b0);
        reg_write(2'd0, 32'h7000_0000);
        reg_write(2'd1, 32'h8000_0000);
        reg_write(2'd2, 32'd4);
        reg_write(2'd3, 32'h3);
        wait_we("rst_mid");
        rstn = 1'b0;
        #1;
        check("rst_mid_strobes", {29'b0, m_req, m_rd, m_we}, 32'h0);
        check("rst_mid_irq", {31'b0, irq}, 32'h0);
        exp_rd_q.delete(); exp_wa_q.delete(); exp_wd_q.delete();
        rd_pending = 1'b0;
        @(negedge clk) rstn = 1'b1;
        reg_read(2'd3, rv); check("rst_mid_stat", rv, 32'h0);
        reg_read(2'd2, rv); check("rst_mid_len", rv, 32'h0);
        run_xfer(32'h0000_1000, 32'h0000_2000, 1, 1'b0, 1'b0, 1'b0, "after_rst");

        run_xfer(32'h4000_0000, 32'h9000_0000, 4, 1'b1, 1'b1, 1'b0, "fixsrc");

        rand_gnt = 1'b1;
        for (int t = 0; t < 8; t++) begin
            run_xfer($urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC, $urandom_range(1, 6),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "random");
        end
        rand_gnt = 1'b0;
        m_gnt = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
